// File: rtl/pll_tune_pkg.sv
// pll_tune_pkg: shared types, config-word layout and packing helper for PLL loop-filter tuning.
package pll_tune_pkg;
   typedef enum logic [2:0] {IDLE, APPLY, WAIT_LOCK, QUALIFY, NEXT, LOCKED, FAIL} state_t;
   localparam int CFG_W   = 11;
   localparam int ICP_LSB = 5;
   localparam int RES_LSB = 2;
   localparam int CAP_LSB = 0;
   function automatic logic [CFG_W-1:0] cfg_pack(input logic [5:0] icp, input logic [2:0] res,
                                                  input logic [1:0] cap);
      return {icp, res, cap};
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level (e.g. a PLL lock).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk)
      if (!rst_n) {q, meta} <= 2'b00;
      else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lpf_autotune.sv
// pll_lpf_autotune: sweeps charge-pump/loop-filter candidates until the PLL holds a qualified lock,
// then watches for lock loss and optionally re-tunes.
module pll_lpf_autotune
   import pll_tune_pkg::*;
#(
   parameter int                         NUM_CFG       = 4,
   parameter logic [NUM_CFG*CFG_W-1:0]   CFG_TABLE     = '0,
   parameter int                         RST_CYCLES    = 16,
   parameter int                         LOCK_TIMEOUT  = 50000,
   parameter int                         STABLE_CYCLES = 1024,
   parameter bit                         AUTO_RELOCK   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pll_lock_i,
   output logic       pll_reset_o,
   output logic [5:0] icpsel_o,
   output logic [2:0] lpfres_o,
   output logic [1:0] lpfcap_o,
   output logic [3:0] cfg_idx_o,
   output logic       busy,
   output logic       locked,
   output logic       fail,
   output logic [7:0] lock_loss_cnt
);
   localparam int CNT_A   = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX = CNT_A > STABLE_CYCLES ? CNT_A : STABLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   state_t            state, nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [3:0]        idx_nxt;
   logic              lock_s, lock_d, fall, locked_nxt;
   logic [CFG_W-1:0]  cfg_sel, cfg0;
   sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock_i), .q(lock_s));
   assign fall        = lock_d & ~lock_s;
   assign cfg_sel     = CFG_TABLE[CFG_W*int'(idx_nxt) +: CFG_W];
   assign cfg0        = CFG_TABLE[CFG_W-1:0];
   assign pll_reset_o = state inside {IDLE, APPLY, FAIL};
   assign busy        = state inside {APPLY, WAIT_LOCK, QUALIFY, NEXT};
   assign fail        = state == FAIL;
   always_comb begin
      nxt     = state;
      idx_nxt = cfg_idx_o;
      cnt_nxt = '0;
      case (state)
         IDLE, FAIL: if (start) begin
            nxt     = APPLY;
            idx_nxt = '0;
         end
         APPLY:
            if (cnt == CW'(RST_CYCLES - 1)) nxt = WAIT_LOCK;
            else cnt_nxt = cnt + 1'b1;
         WAIT_LOCK:
            if (lock_s) nxt = QUALIFY;
            else if (cnt == CW'(LOCK_TIMEOUT - 1)) nxt = NEXT;
            else cnt_nxt = cnt + 1'b1;
         QUALIFY:
            if (!lock_s) nxt = NEXT;
            else if (cnt == CW'(STABLE_CYCLES - 1)) nxt = LOCKED;
            else cnt_nxt = cnt + 1'b1;
         NEXT:
            if (cfg_idx_o < 4'(NUM_CFG - 1)) begin
               nxt     = APPLY;
               idx_nxt = cfg_idx_o + 1'b1;
            end else nxt = FAIL;
         LOCKED:
            if (start) begin
               nxt     = APPLY;
               idx_nxt = '0;
            end else if (fall && AUTO_RELOCK) nxt = APPLY;
         default: nxt = IDLE;
      endcase
   end
   // once dropped in LOCKED, locked stays low until a fresh qualification
   assign locked_nxt = (nxt == LOCKED) && (state != LOCKED || (locked && !fall));
   always_ff @(posedge clk)
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         cfg_idx_o     <= '0;
         icpsel_o      <= cfg0[ICP_LSB +: 6];
         lpfres_o      <= cfg0[RES_LSB +: 3];
         lpfcap_o      <= cfg0[CAP_LSB +: 2];
         locked        <= 1'b0;
         lock_d        <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         state     <= nxt;
         cnt       <= cnt_nxt;
         cfg_idx_o <= idx_nxt;
         lock_d    <= lock_s;
         locked    <= locked_nxt;
         if (nxt == APPLY && state != APPLY) begin
            icpsel_o <= cfg_sel[ICP_LSB +: 6];
            lpfres_o <= cfg_sel[RES_LSB +: 3];
            lpfcap_o <= cfg_sel[CAP_LSB +: 2];
         end
         if (state == LOCKED && fall && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
endmodule

// File: tb/tb_pll_lpf_autotune.sv
// tb_pll_lpf_autotune: scoreboard bench with a per-index PLL lock model.
module tb_pll_lpf_autotune;
   localparam logic [5:0] ICP [4] = '{6'h01, 6'h3F, 6'h15, 6'h2A};
   localparam logic [2:0] RES [4] = '{3'd1, 3'd7, 3'd2, 3'd5};
   localparam logic [1:0] CAP [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
   localparam logic [43:0] TABLE = {pll_tune_pkg::cfg_pack(ICP[3], RES[3], CAP[3]),
                                    pll_tune_pkg::cfg_pack(ICP[2], RES[2], CAP[2]),
                                    pll_tune_pkg::cfg_pack(ICP[1], RES[1], CAP[1]),
                                    pll_tune_pkg::cfg_pack(ICP[0], RES[0], CAP[0])};
   typedef struct {bit is_fail; int idx; int loss;} exp_t;
   logic       clk = 0, rst_n = 0, start = 0, pll_lock_i = 0;
   logic       pll_reset_o, busy, locked, fail;
   logic [5:0] icpsel_o;
   logic [2:0] lpfres_o;
   logic [1:0] lpfcap_o;
   logic [3:0] cfg_idx_o;
   logic [7:0] lock_loss_cnt;
   int         n_chk = 0, n_fail = 0;
   int         dly [4], drp [4];
   bit         force_drop = 0;
   int         rel = 0, a_run = 0, l_run = 0;
   int         apply_len [$], apply_idx [$], low_len [$];
   exp_t       sb [$];
   always #5 clk = ~clk;
   pll_lpf_autotune #(.NUM_CFG(4), .CFG_TABLE(TABLE), .RST_CYCLES(4), .LOCK_TIMEOUT(16),
                      .STABLE_CYCLES(8), .AUTO_RELOCK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pll_lock_i(pll_lock_i), .pll_reset_o(pll_reset_o),
      .icpsel_o(icpsel_o), .lpfres_o(lpfres_o), .lpfcap_o(lpfcap_o), .cfg_idx_o(cfg_idx_o),
      .busy(busy), .locked(locked), .fail(fail), .lock_loss_cnt(lock_loss_cnt));
   // PLL model: locks dly cycles after reset release, optionally drops drp cycles later
   always @(posedge clk) begin
      #2;
      if (pll_reset_o !== 1'b0) begin
         rel = 0;
         pll_lock_i = 1'b0;
      end else begin
         rel++;
         pll_lock_i = !force_drop && dly[cfg_idx_o] >= 0 && rel >= dly[cfg_idx_o] &&
                      !(drp[cfg_idx_o] >= 0 && rel >= dly[cfg_idx_o] + drp[cfg_idx_o]);
      end
   end
   always @(negedge clk) begin
      if (!rst_n) begin
         a_run = 0;
         l_run = 0;
      end else begin
         if (busy && pll_reset_o) a_run++;
         else if (a_run > 0) begin
            apply_len.push_back(a_run);
            apply_idx.push_back(int'(cfg_idx_o));
            a_run = 0;
         end
         if (busy && !pll_reset_o) l_run++;
         else if (l_run > 0) begin
            low_len.push_back(l_run);
            l_run = 0;
         end
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic check_reset();
      check("rst_pll_reset", pll_reset_o, 1);
      check("rst_idx", cfg_idx_o, 0);
      check("rst_cfg", {icpsel_o, lpfres_o, lpfcap_o}, {ICP[0], RES[0], CAP[0]});
      check("rst_busy", busy, 0);
      check("rst_locked", locked, 0);
      check("rst_fail", fail, 0);
      check("rst_loss", lock_loss_cnt, 0);
   endtask
   task automatic do_reset();
      @(negedge clk) rst_n = 0;
      @(negedge clk) check_reset();
      rst_n = 1;
      apply_len.delete();
      apply_idx.delete();
      low_len.delete();
   endtask
   task automatic set_pll(input int d0, d1, d2, d3, input int p2);
      dly = '{d0, d1, d2, d3};
      drp = '{-1, -1, p2, -1};
   endtask
   task automatic pulse_start();
      start = 1;
      @(negedge clk) start = 0;
   endtask
   task automatic expect_out(input bit f, input int idx, input int loss);
      exp_t e;
      e.is_fail = f;
      e.idx = idx;
      e.loss = loss;
      sb.push_back(e);
   endtask
   task automatic wait_outcome(input int budget);
      exp_t e;
      bit pb, hit;
      hit = 0;
      pb = busy;
      for (int n = 0; n < budget && !hit; n++) begin
         pb = busy;
         @(negedge clk);
         hit = locked || fail;
      end
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      if (!hit) begin
         check("outcome_timeout", 0, 1);
         return;
      end
      check("out_fail", fail, e.is_fail);
      check("out_locked", locked, !e.is_fail);
      check("out_idx", cfg_idx_o, e.idx);
      check("out_cfg", {icpsel_o, lpfres_o, lpfcap_o}, {ICP[e.idx], RES[e.idx], CAP[e.idx]});
      check("out_loss", lock_loss_cnt, e.loss);
      check("out_busy", busy, 0);
      if (e.is_fail) check("fail_pll_reset", pll_reset_o, 1);
      else check("busy_fall_with_lock", pb, 1);
   endtask
   task automatic wait_wait_state(input int idx, input int budget);
      bit hit;
      hit = 0;
      for (int n = 0; n < budget && !hit; n++) begin
         @(negedge clk);
         hit = busy && !pll_reset_o && cfg_idx_o == 4'(idx);
      end
      if (!hit) check("wait_state_timeout", 0, 1);
   endtask
   task automatic check_applies(input int n);
      check("n_apply", apply_len.size(), n);
      for (int i = 0; i < n && i < apply_len.size(); i++) begin
         check("apply_len", apply_len[i], 4);
         check("apply_idx", apply_idx[i], i);
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      set_pll(-1, -1, -1, -1, -1);
      // index 0 locks 5 cycles after release
      do_reset();
      set_pll(5, -1, -1, -1, -1);
      expect_out(0, 0, 0);
      pulse_start();
      wait_outcome(100);
      check_applies(1);
      // index 0 times out, index 1 locks
      do_reset();
      set_pll(-1, 3, -1, -1, -1);
      expect_out(0, 1, 0);
      pulse_start();
      wait_outcome(150);
      check_applies(2);
      check("timeout_plus_next", low_len.size() > 0 ? low_len[0] : -1, 17);
      // index 2 drops in QUALIFY, index 3 locks
      do_reset();
      set_pll(-1, -1, 2, 2, 4);
      expect_out(0, 3, 0);
      pulse_start();
      wait_outcome(250);
      check_applies(4);
      // nothing locks
      do_reset();
      set_pll(-1, -1, -1, -1, -1);
      expect_out(1, 3, 0);
      pulse_start();
      wait_outcome(250);
      pulse_start();
      check("restart_fail_clr", fail, 0);
      check("restart_idx", cfg_idx_o, 0);
      check("restart_busy", busy, 1);
      // lock loss and auto relock at index 1, saturating counter
      do_reset();
      set_pll(-1, 2, -1, -1, -1);
      expect_out(0, 1, 0);
      pulse_start();
      wait_outcome(150);
      apply_idx.delete();
      for (int i = 0; i < 300; i++) begin
         force_drop = 1;
         repeat (10) @(negedge clk);
         force_drop = 0;
         expect_out(0, 1, i + 1 > 255 ? 255 : i + 1);
         wait_outcome(80);
         check("relock_apply_idx", apply_idx.size() > 0 ? apply_idx.pop_front() : -1, 1);
      end
      // start while busy is ignored; reset during WAIT_LOCK at index 2
      do_reset();
      set_pll(-1, -1, -1, -1, -1);
      pulse_start();
      wait_wait_state(1, 100);
      pulse_start();
      check("start_ignored_idx", cfg_idx_o, 1);
      check("start_ignored_busy", busy, 1);
      wait_wait_state(2, 100);
      repeat (3) @(negedge clk);
      rst_n = 0;
      @(negedge clk) check_reset();
      rst_n = 1;
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pll_lpf_autotune.md
Name: pll_lpf_autotune

Overview:
- Run-time controller for the PLL dynamic charge-pump and loop-filter inputs (ICPSEL/LPFRES/LPFCAP, DYN_ICP_SEL/DYN_LPF_SEL enabled).
- Sweeps a parametrised table of candidate settings. For each candidate it pulses PLL reset, waits for lock and qualifies lock stability, then holds the first setting that passes.
- Monitors for lock loss and re-tunes automatically. Runs on the free-running 50 MHz PLL reference clock, never on a PLL output.

Parameters:
- NUM_CFG, 4, number of candidate settings (1..16).
- CFG_TABLE, {4{11'h000}}, packed NUM_CFG×11-bit table; entry i = bits [11i+10:11i] = {icpsel[5:0], lpfres[2:0], lpfcap[1:0]}.
- RST_CYCLES, 16, cycles PLL reset is held per attempt (≥1).
- LOCK_TIMEOUT, 50000, cycles allowed for lock to rise after reset release (≥2).
- STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required to qualify (≥1).
- AUTO_RELOCK, 1, 1 = lock loss in LOCKED triggers a re-sweep; 0 = flag only.

Ports:
- clk  in  1  reference clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle sweep request.
- pll_lock_i  in  1  PLL lock, asynchronous to clk.
- pll_reset_o  out  1  PLL reset, active high.
- icpsel_o  out  6  to PLL ICPSEL.
- lpfres_o  out  3  to PLL LPFRES.
- lpfcap_o  out  2  to PLL LPFCAP.
- cfg_idx_o  out  4  current candidate index.
- busy  out  1  sweep in progress.
- locked  out  1  qualified lock held.
- fail  out  1  all candidates exhausted.
- lock_loss_cnt  out  8  saturating count of lock losses seen in LOCKED.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge) values:
  - state IDLE, pll_reset_o=1, cfg_idx_o=0.
  - icpsel_o/lpfres_o/lpfcap_o = entry 0.
  - busy=0, locked=0, fail=0, lock_loss_cnt=0, synchroniser cleared.
  - Reset mid-sweep aborts immediately with the same values.
- pll_lock_i passes through a 2-FF synchroniser to give lock_s, 2-cycle latency. All decisions use lock_s only.
- Setting outputs are registered from CFG_TABLE[cfg_idx_o]. They change only in the cycle APPLY is entered, so they are always stable while pll_reset_o=1 before release.
- States:
  - IDLE: pll_reset_o=1. start → APPLY with idx=0, fail cleared.
  - APPLY: pll_reset_o=1, busy=1, held exactly RST_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK: pll_reset_o=0, counter from 0.
    - lock_s=1 → QUALIFY.
    - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 → NEXT.
  - QUALIFY: counts consecutive lock_s=1.
    - Reaching STABLE_CYCLES → LOCKED.
    - Any lock_s=0 → NEXT. There is no second chance on the same index.
  - NEXT (1 cycle):
    - idx<NUM_CFG-1 → idx+1, APPLY.
    - Otherwise → FAIL.
  - LOCKED: locked=1, busy=0, pll_reset_o=0.
    - lock_s falling → lock_loss_cnt+1 (saturates at 255) and locked=0 next cycle.
    - If AUTO_RELOCK=1 → APPLY with the same idx; the sweep continues upward from there, no wrap.
    - If AUTO_RELOCK=0 → stay in LOCKED with locked tracking lock_s (reasserted only by a new start).
  - FAIL: fail=1, busy=0, pll_reset_o=1, outputs hold the last entry. start → APPLY idx=0, fail=0.
- start while busy=1 is ignored. start in LOCKED restarts the sweep from idx 0 (locked=0 next cycle).
- Simultaneous start and lock loss in LOCKED: start wins, and lock_loss_cnt still increments.
- lock_loss_cnt is cleared only by reset.
- Counters are sized $clog2(max+1); no wrap is possible inside any state.

Decomposition:
- Package pll_tune_pkg:
  - state enum (IDLE, APPLY, WAIT_LOCK, QUALIFY, NEXT, LOCKED, FAIL).
  - CFG_W=11.
  - field offsets ICP_LSB=5, RES_LSB=2, CAP_LSB=0.
  - cfg-pack helper function.
- One sub-module: sync_2ff, the lock synchroniser, reusable elsewhere for other PLL lock signals.

Test Plan:
Bench parameters for all scenarios: NUM_CFG=4, RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, model PLL with programmable per-index lock behaviour.
- Index 0 locks 5 cycles after reset release and stays high → pll_reset_o high exactly 4 cycles; locked=1 with cfg_idx_o=0; icpsel/lpfres/lpfcap equal entry 0; busy falls the same cycle locked rises.
- Index 0 never locks, index 1 locks → index 0 timeout after 16 cycles; one NEXT cycle; second 4-cycle reset with entry 1 outputs; locked=1 with cfg_idx_o=1.
- Index 2 locks then drops after 3 cycles in QUALIFY, index 3 locks cleanly → cfg_idx_o advances to 3; locked=1; lock_loss_cnt stays 0.
- No index ever locks → fail=1, busy=0, pll_reset_o=1, cfg_idx_o=3. A subsequent start clears fail and restarts at idx 0.
- From LOCKED at idx 1, drop pll_lock_i for 10 cycles (AUTO_RELOCK=1) → lock_loss_cnt=1; APPLY re-entered at idx 1; relock gives locked=1 at idx 1. Repeat 300 times → lock_loss_cnt saturates at 255.
- Assert rst_n=0 during WAIT_LOCK at idx 2 → next cycle all outputs at reset values; start pulsed during busy is ignored (no index reset).
